// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache, 16-byte lines, single outstanding refill
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  valid_from_fetcher,
    input  logic [ADDR_WIDTH-1:0] addr_from_fetcher,
    input  logic                  flush_from_fetcher,
    output logic                  ready_to_fetcher,
    output logic [31:0]           inst_to_fetcher,
    output logic                  valid_to_mem,
    output logic [ADDR_WIDTH-1:0] addr_to_mem,
    input  logic                  ready_from_mem,
    input  logic [127:0]          data_from_mem,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 4;
    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                  state_q;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [127:0]            data_q [LINES];
    logic                    ready_q;
    logic [31:0]             inst_q;
    logic                    vmem_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [1:0]              word_q;
    logic                    flushed_q;

    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_WIDTH-1:0]  fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    req_hit;
    logic                    accept;
    logic                    fill;
    logic                    unused_byte_offset;

    function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] w);
        return line[{w, 5'b0} +: 32];
    endfunction

    assign req_idx  = addr_from_fetcher[INDEX_WIDTH+3:4];
    assign req_tag  = addr_from_fetcher[ADDR_WIDTH-1:INDEX_WIDTH+4];
    assign fill_idx = mem_addr_q[INDEX_WIDTH+3:4];
    assign fill_tag = mem_addr_q[ADDR_WIDTH-1:INDEX_WIDTH+4];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept   = valid_from_fetcher && !ready_q && !flush_from_fetcher;
    assign fill     = rdy && (state_q == MISS) && ready_from_mem;
    assign unused_byte_offset = ^addr_from_fetcher[1:0];

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

    // Line storage needs no reset: valid_q alone gates whether it is ever read.
    always_ff @(posedge clk) begin
        if (!rst && fill) begin
            data_q[fill_idx] <= data_from_mem;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            ready_q    <= 1'b0;
            inst_q     <= '0;
            vmem_q     <= 1'b0;
            mem_addr_q <= '0;
            word_q     <= '0;
            flushed_q  <= 1'b0;
`ifdef ICACHE_PERF_CNT_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else if (rdy) begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_hit) begin
                            ready_q <= 1'b1;
                            inst_q  <= sel_word(data_q[req_idx], addr_from_fetcher[3:2]);
`ifdef ICACHE_PERF_CNT_EN
                            hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
                        end else begin
                            mem_addr_q <= {addr_from_fetcher[ADDR_WIDTH-1:4], 4'b0};
                            word_q     <= addr_from_fetcher[3:2];
                            vmem_q     <= 1'b1;
                            flushed_q  <= 1'b0;
                            state_q    <= MISS;
`ifdef ICACHE_PERF_CNT_EN
                            miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
                        end
                    end
                end
                MISS: begin
                    // The memory read cannot be cancelled; a flush only drops the answer.
                    if (ready_from_mem) begin
                        valid_q[fill_idx] <= 1'b1;
                        vmem_q            <= 1'b0;
                        state_q           <= IDLE;
                        if (!(flushed_q || flush_from_fetcher)) begin
                            ready_q <= 1'b1;
                            inst_q  <= sel_word(data_from_mem, word_q);
                        end
                    end else if (flush_from_fetcher) begin
                        flushed_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_to_fetcher = ready_q;
    assign inst_to_fetcher  = inst_q;
    assign valid_to_mem     = vmem_q;
    assign addr_to_mem      = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache against a line-level cache model
// Counter expectations follow ICACHE_PERF_CNT_EN.
module tb_icache;

    logic         clk = 1'b0;
    logic         rst, rdy, valid_f, flush_f, ready_f, ready_m, vmem;
    logic [31:0]  addr_f, inst, addr_m, hc, mc;
    logic [127:0] data_m;

    icache #(.ADDR_WIDTH(32), .INDEX_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .valid_from_fetcher(valid_f), .addr_from_fetcher(addr_f), .flush_from_fetcher(flush_f),
        .ready_to_fetcher(ready_f), .inst_to_fetcher(inst),
        .valid_to_mem(vmem), .addr_to_mem(addr_m),
        .ready_from_mem(ready_m), .data_from_mem(data_m),
        .hit_count(hc), .miss_count(mc)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          mvalid [16];
    logic [23:0] mtag   [16];
    int unsigned m_hits, m_misses;
    bit          prev_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: every byte is a fixed function of its address, so lines differ per tag.
    function automatic logic [7:0] mem_byte(input logic [31:0] base, input int k);
        logic [31:0] v;
        v = base + 32'(k) + (base >> 8) + 32'd3 * (base >> 16) - 32'd16;
        return v[7:0];
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] base);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = mem_byte(base, k);
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] base;
        int          w;
        base = {a[31:4], 4'b0};
        w    = int'(a[3:2]);
        return {mem_byte(base, 4*w+3), mem_byte(base, 4*w+2), mem_byte(base, 4*w+1), mem_byte(base, 4*w)};
    endfunction

    task automatic check_counts();
`ifdef ICACHE_PERF_CNT_EN
        chk("hit_count", hc, m_hits);
        chk("miss_count", mc, m_misses);
`else
        chk("hit_count", hc, 32'd0);
        chk("miss_count", mc, 32'd0);
`endif
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        m_hits = 0; m_misses = 0; prev_resp = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); @(negedge clk);
        chk("idle_ready", ready_f, 1'b0);
        prev_resp = 1'b0;
    endtask

    // One fetch from a negedge to the negedge after its outcome; lat = memory cycles,
    // flush_at/stall_at = MISS cycle for a flush / 3-cycle rdy drop (stall_at>=0 on a hit stalls the response).
    task automatic do_fetch(input logic [31:0] a, input int lat, input int flush_at, input int stall_at,
                            output logic [31:0] got, output bit was_hit);
        logic [3:0]  idx;
        logic [23:0] tag;
        logic [31:0] base;
        bit          flushed;
        idx = a[7:4]; tag = a[31:8]; base = {a[31:4], 4'b0};
        was_hit = mvalid[idx] && (mtag[idx] == tag);
        got = 32'hx;
        valid_f = 1'b1; addr_f = a;
        if (prev_resp) begin
            @(posedge clk); @(negedge clk);
            chk("bubble_ready", ready_f, 1'b0);
        end
        @(posedge clk); @(negedge clk);
        if (was_hit) begin
            m_hits++;
            chk("hit_ready", ready_f, 1'b1);
            chk("hit_inst", inst, word_of(a));
            chk("hit_no_mem", vmem, 1'b0);
            check_counts();
            got = inst; valid_f = 1'b0;
            if (stall_at >= 0) begin
                rdy = 1'b0;
                repeat (3) begin
                    @(posedge clk); @(negedge clk);
                    chk("stall_hit_ready", ready_f, 1'b1);
                    chk("stall_hit_inst", inst, word_of(a));
                end
                rdy = 1'b1;
            end
            prev_resp = 1'b1;
        end else begin
            m_misses++;
            flushed = 1'b0;
            check_counts();
            for (int c = 0; c < lat; c++) begin
                if (c > 0) begin
                    @(posedge clk); @(negedge clk);
                end
                flush_f = 1'b0;
                chk("miss_valid_to_mem", vmem, 1'b1);
                chk("miss_addr_to_mem", addr_m, base);
                chk("miss_no_ready", ready_f, 1'b0);
                if (c == stall_at) begin
                    rdy = 1'b0;
                    repeat (3) begin
                        @(posedge clk); @(negedge clk);
                        chk("stall_miss_valid", vmem, 1'b1);
                        chk("stall_miss_addr", addr_m, base);
                        chk("stall_miss_ready", ready_f, 1'b0);
                    end
                    rdy = 1'b1;
                end
                if (c == flush_at) begin
                    flush_f = 1'b1; valid_f = 1'b0; flushed = 1'b1;
                end
                if (c == lat - 1) begin
                    ready_m = 1'b1; data_m = line_data(base);
                end
            end
            @(posedge clk); @(negedge clk);
            ready_m = 1'b0; flush_f = 1'b0; valid_f = 1'b0;
            data_m = {$urandom, $urandom, $urandom, $urandom};
            chk("fill_valid_to_mem", vmem, 1'b0);
            chk("fill_ready", ready_f, 32'(!flushed));
            if (!flushed) chk("fill_inst", inst, word_of(a));
            got = inst;
            mvalid[idx] = 1'b1; mtag[idx] = tag;
            prev_resp = !flushed;
        end
    endtask

    // Response pulses never repeat across an enabled edge.
    logic rdy_e = 1'b0;
    logic prev_ready = 1'b0;
    always @(posedge clk) rdy_e <= rdy;
    always @(negedge clk) begin
        if (!rst && prev_ready && rdy_e) chk("single_cycle_ready", ready_f, 1'b0);
        prev_ready = ready_f;
    end

    initial begin
        logic [31:0] got;
        bit          h;
        int          lat, fa, sa;
        logic [31:0] a;
        rst = 1'b1; rdy = 1'b1; valid_f = 1'b0; flush_f = 1'b0; ready_m = 1'b0;
        addr_f = '0; data_m = '0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_ready", ready_f, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_vmem", vmem, 1'b0);
        chk("rst_addr", addr_m, 32'h0);
        chk("rst_hc", hc, 32'h0);
        chk("rst_mc", mc, 32'h0);
        rst = 1'b0;
        idle_cycle();

        do_fetch(32'h0000_1004, 5, -1, -1, got, h);
        chk("cold_miss_inst", got, 32'h0706_0504);
        chk("cold_miss_kind", 32'(h), 32'd0);
        do_fetch(32'h0000_100C, 1, -1, -1, got, h);
        chk("hit_inst_lit", got, 32'h0F0E_0D0C);
        chk("hit_kind", 32'(h), 32'd1);
        do_fetch(32'h0000_1100, 3, -1, -1, got, h);
        chk("evict_inst", got, 32'h0403_0201);
        do_fetch(32'h0000_1000, 2, -1, -1, got, h);
        chk("reevict_kind", 32'(h), 32'd0);
        chk("reevict_inst", got, 32'h0302_0100);
`ifdef ICACHE_PERF_CNT_EN
        chk("seq_miss_count", mc, 32'd3);
        chk("seq_hit_count", hc, 32'd1);
`endif

        do_fetch(32'h0000_2040, 5, 2, -1, got, h);
        do_fetch(32'h0000_2048, 1, -1, -1, got, h);
        chk("after_flush_kind", 32'(h), 32'd1);
        chk("after_flush_inst", got, 32'h5B5A_5958);

        do_fetch(32'h0000_1000, 1, -1, 0, got, h);
        do_fetch(32'h0000_5000, 4, -1, 1, got, h);
        do_fetch(32'h0000_6000, 3, 2, -1, got, h);
        do_fetch(32'h0000_6004, 1, -1, -1, got, h);
        chk("flush_with_fill_kind", 32'(h), 32'd1);

        idle_cycle();
        valid_f = 1'b1; addr_f = 32'h0000_1000; flush_f = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("flush_blocks_accept", ready_f, 1'b0);
        chk("flush_blocks_mem", vmem, 1'b0);
        valid_f = 1'b0; flush_f = 1'b0;
        ready_m = 1'b1; data_m = '1;
        @(posedge clk); @(negedge clk);
        ready_m = 1'b0;
        chk("spurious_ready", ready_f, 1'b0);
        check_counts();
        do_fetch(32'h0000_1008, 1, -1, -1, got, h);
        chk("spurious_no_corrupt", got, word_of(32'h0000_1008));

        idle_cycle();
        valid_f = 1'b1; addr_f = 32'h0000_3000;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_vmem", vmem, 1'b1);
        @(posedge clk); @(negedge clk);
        valid_f = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midmiss_rst_vmem", vmem, 1'b0);
        chk("midmiss_rst_addr", addr_m, 32'h0);
        chk("midmiss_rst_hc", hc, 32'h0);
        chk("midmiss_rst_mc", mc, 32'h0);
        clear_model();
        @(negedge clk); rst = 1'b0;
        do_fetch(32'h0000_1004, 2, -1, -1, got, h);
        chk("post_rst_miss", 32'(h), 32'd0);

        for (int n = 0; n < 300; n++) begin
            a   = {16'h0, 8'(8'h10 + $urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom)};
            lat = $urandom_range(1, 6);
            fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat - 1) : -1;
            sa  = ($urandom_range(0, 6) == 0) ? $urandom_range(0, lat - 1) : -1;
            do_fetch(a, lat, fa, sa, got, h);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        check_counts();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
